// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, types and twiddle-index helpers for the NTT sequencer
package ntt_pkg;

   localparam logic [22:0] Q     = 23'd8380417;
   localparam int          LOG_N = 8;
   localparam int          N     = 1 << LOG_N;

   typedef logic [LOG_N-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Cooley-Tukey twiddle index: one new power per group, doubling groups per stage
   function automatic int tw_fwd(input int stage, input int grp);
      return (1 << stage) + grp;
   endfunction

   // Gentleman-Sande twiddle index: walks the table downwards as groups shrink
   function automatic int tw_inv(input int log_n, input int stage, input int grp);
      return ((1 << log_n) >> stage) - 1 - grp;
   endfunction

endpackage

// File: rtl/ntt_ctrl_if.sv
// rtl/ntt_ctrl_if.sv - command, issue and write-back signals of the NTT sequencer
interface ntt_ctrl_if #(
   parameter int LOG_N = 8,
   parameter int SW    = $clog2(LOG_N)
);
   logic             start_i;
   logic             mode_i;
   logic             stall_i;
   logic             busy_o;
   logic             done_o;
   logic [SW-1:0]    stage_o;
   logic             rd_valid_o;
   logic [LOG_N-1:0] rd_addr_a_o;
   logic [LOG_N-1:0] rd_addr_b_o;
   logic [LOG_N-1:0] tw_addr_o;
   logic             sel_butterfly_o;
   logic             sel_red_o;
   logic             wr_valid_o;
   logic [LOG_N-1:0] wr_addr_a_o;
   logic [LOG_N-1:0] wr_addr_b_o;

   // Command side: drives start/mode/stall, observes everything else
   modport master (
      output start_i, mode_i, stall_i,
      input  busy_o, done_o, stage_o, rd_valid_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
             sel_butterfly_o, sel_red_o, wr_valid_o, wr_addr_a_o, wr_addr_b_o
   );

   // Sequencer side
   modport slave (
      input  start_i, mode_i, stall_i,
      output busy_o, done_o, stage_o, rd_valid_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
             sel_butterfly_o, sel_red_o, wr_valid_o, wr_addr_a_o, wr_addr_b_o
   );
endinterface

// File: rtl/ntt_delay_line.sv
// rtl/ntt_delay_line.sv - LAT-deep shift register aligning write-back with the butterfly pipe
module ntt_delay_line #(
   parameter int LAT = 2,
   parameter int AW  = 8
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          valid_i,
   input  logic [AW-1:0] addr_a_i,
   input  logic [AW-1:0] addr_b_i,
   output logic          valid_o,
   output logic [AW-1:0] addr_a_o,
   output logic [AW-1:0] addr_b_o
);
   logic [LAT-1:0] valid_q;
   logic [AW-1:0]  addr_a_q [LAT];
   logic [AW-1:0]  addr_b_q [LAT];

   // Shift every cycle; stalls upstream appear here as bubbles, never as holds
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= '0;
         for (int k = 0; k < LAT; k++) begin
            addr_a_q[k] <= '0;
            addr_b_q[k] <= '0;
         end
      end else begin
         valid_q[0]  <= valid_i;
         addr_a_q[0] <= addr_a_i;
         addr_b_q[0] <= addr_b_i;
         for (int k = 1; k < LAT; k++) begin
            valid_q[k]  <= valid_q[k-1];
            addr_a_q[k] <= addr_a_q[k-1];
            addr_b_q[k] <= addr_b_q[k-1];
         end
      end
   end

   assign valid_o  = valid_q[LAT-1];
   assign addr_a_o = addr_a_q[LAT-1];
   assign addr_b_o = addr_b_q[LAT-1];

endmodule

// File: rtl/ntt_ctrl.sv
// rtl/ntt_ctrl.sv - stage/butterfly sequencer feeding the NTT/INTT butterfly datapath
module ntt_ctrl
   import ntt_pkg::*;
#(
   parameter int PIPE_LAT = 2
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   ntt_ctrl_if.slave bus
);
   localparam int SW   = $clog2(LOG_N);
   localparam int IW   = LOG_N - 1;
   localparam int HALF = N / 2;

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_DRAIN = DRAIN;
   localparam logic [1:0] S_DONE  = DONE;

   localparam logic [IW-1:0] I_LAST     = '1;
   localparam logic [SW-1:0] STAGE_LAST = SW'(LOG_N - 1);
   localparam logic [3:0]    DRAIN_LAST = 4'(PIPE_LAT - 1);

   logic [1:0]    state_q, state_d;
   logic [SW-1:0] stage_q, stage_d;
   logic [IW-1:0] i_q, i_d;
   logic [3:0]    drain_q, drain_d;
   logic          mode_q, mode_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          rd_valid_q;
   addr_t         rd_a_q, rd_b_q, tw_q;
   logic          sel_red_q;

   logic          issue_c;
   addr_t         addr_a_c, addr_b_c, tw_c;

   logic          wr_valid_w;
   addr_t         wr_a_w, wr_b_w;

   assign issue_c = (state_q == S_RUN) && !bus.stall_i;

   // Butterfly i of the current stage: a has a zero inserted at the span bit, b is a + span
   always_comb begin : addr_gen
      int len, grp, off, pos_a, tw;
      if (mode_q == 1'b0) begin
         len = HALF >> stage_q;
         grp = int'(i_q) >> (LOG_N - 1 - int'(stage_q));
         tw  = tw_fwd(int'(stage_q), grp);
      end else begin
         len = 1 << stage_q;
         grp = int'(i_q) >> stage_q;
         tw  = tw_inv(LOG_N, int'(stage_q), grp);
      end
      off      = int'(i_q) & (len - 1);
      pos_a    = 2 * len * grp + off;
      addr_a_c = addr_t'(pos_a);
      addr_b_c = addr_t'(pos_a + len);
      tw_c     = addr_t'(tw);
   end

   // Next-state: issue 128 butterflies, drain the pipe, then advance the stage or finish
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      i_d     = i_q;
      drain_d = drain_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               state_d = S_RUN;
               mode_d  = bus.mode_i;
               stage_d = '0;
               i_d     = '0;
            end
         end
         S_RUN: begin
            if (!bus.stall_i) begin
               if (i_q == I_LAST) begin
                  state_d = S_DRAIN;
                  drain_d = '0;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               if (stage_q == STAGE_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  stage_d = stage_q + 1'b1;
                  i_d     = '0;
               end
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      done_d = (state_q == S_DONE);
      busy_d = busy_q;
      if ((state_q == S_IDLE) && bus.start_i) begin
         busy_d = 1'b1;
      end else if (done_q) begin
         busy_d = 1'b0;
      end
   end

   // Control state registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         stage_q <= '0;
         i_q     <= '0;
         drain_q <= '0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         i_q     <= i_d;
         drain_q <= drain_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Registered issue outputs; addresses hold their last value between issues
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_valid_q <= 1'b0;
         rd_a_q     <= '0;
         rd_b_q     <= '0;
         tw_q       <= '0;
         sel_red_q  <= 1'b0;
      end else begin
         rd_valid_q <= issue_c;
         sel_red_q  <= issue_c && mode_q && (stage_q == STAGE_LAST);
         if (issue_c) begin
            rd_a_q <= addr_a_c;
            rd_b_q <= addr_b_c;
            tw_q   <= tw_c;
         end
      end
   end

   ntt_delay_line #(
      .LAT (PIPE_LAT),
      .AW  (LOG_N)
   ) u_delay (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .valid_i  (rd_valid_q),
      .addr_a_i (rd_a_q),
      .addr_b_i (rd_b_q),
      .valid_o  (wr_valid_w),
      .addr_a_o (wr_a_w),
      .addr_b_o (wr_b_w)
   );

   assign bus.busy_o          = busy_q;
   assign bus.done_o          = done_q;
   assign bus.stage_o         = stage_q;
   assign bus.rd_valid_o      = rd_valid_q;
   assign bus.rd_addr_a_o     = rd_a_q;
   assign bus.rd_addr_b_o     = rd_b_q;
   assign bus.tw_addr_o       = tw_q;
   assign bus.sel_butterfly_o = mode_q;
   assign bus.sel_red_o       = sel_red_q;
   assign bus.wr_valid_o      = wr_valid_w;
   assign bus.wr_addr_a_o     = wr_a_w;
   assign bus.wr_addr_b_o     = wr_b_w;

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb/tb_ntt_ctrl.sv - randomized self-checking bench for ntt_ctrl against a transform-level model
module tb_ntt_ctrl;
   import ntt_pkg::*;

   localparam int PL = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ntt_ctrl_if bus ();

   ntt_ctrl #(.PIPE_LAT(PL)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Expected issue list for one transform, in issue order
   int exp_a [1024];
   int exp_b [1024];
   int exp_tw [1024];
   int exp_red [1024];

   // Write-back history indexed by cycle since the start edge
   bit hv [4096];
   int ha [4096];
   int hb [4096];

   bit e_en = 1'b0;
   bit e_rdv, e_red, e_sb, e_busy, e_done, e_wrv;
   int e_a, e_b, e_tw, e_stage, e_wa, e_wb;

   bit sb_en = 1'b0;
   int r_cnt, w_cnt, d_cnt;
   int hits [8][256];

   int m_phase, m_stage, m_k, m_dl, m_idx;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rd_valid"}, int'(bus.rd_valid_o), 0);
      check({tag, "_wr_valid"}, int'(bus.wr_valid_o), 0);
      check({tag, "_busy"}, int'(bus.busy_o), 0);
      check({tag, "_done"}, int'(bus.done_o), 0);
      check({tag, "_stage"}, int'(bus.stage_o), 0);
      check({tag, "_rd_a"}, int'(bus.rd_addr_a_o), 0);
      check({tag, "_rd_b"}, int'(bus.rd_addr_b_o), 0);
      check({tag, "_tw"}, int'(bus.tw_addr_o), 0);
      check({tag, "_wr_a"}, int'(bus.wr_addr_a_o), 0);
      check({tag, "_wr_b"}, int'(bus.wr_addr_b_o), 0);
      check({tag, "_sel_bf"}, int'(bus.sel_butterfly_o), 0);
      check({tag, "_sel_red"}, int'(bus.sel_red_o), 0);
   endtask

   // Butterfly pairs from span/group arithmetic: span len, group = i/len, offset = i%len
   function automatic void build_list(input int mode);
      int idx;
      idx = 0;
      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < 128; i++) begin
            int len, grp, off, a;
            len = (mode != 0) ? (1 << s) : (128 >> s);
            grp = i / len;
            off = i % len;
            a   = 2 * len * grp + off;
            exp_a[idx]   = a;
            exp_b[idx]   = a + len;
            exp_tw[idx]  = (mode != 0) ? ((256 >> s) - 1 - grp) : ((1 << s) + grp);
            exp_red[idx] = ((mode != 0) && (s == 7)) ? 1 : 0;
            idx++;
         end
      end
   endfunction

   // Per-cycle comparison against the model, plus a write-coverage and ordering scoreboard
   always @(negedge clk) begin
      if (rst_n && e_en) begin
         check("rd_valid", int'(bus.rd_valid_o), int'(e_rdv));
         if (e_rdv && bus.rd_valid_o) begin
            check("rd_addr_a", int'(bus.rd_addr_a_o), e_a);
            check("rd_addr_b", int'(bus.rd_addr_b_o), e_b);
            check("tw_addr", int'(bus.tw_addr_o), e_tw);
         end
         check("sel_red", int'(bus.sel_red_o), int'(e_red));
         check("sel_butterfly", int'(bus.sel_butterfly_o), int'(e_sb));
         check("stage", int'(bus.stage_o), e_stage);
         check("busy", int'(bus.busy_o), int'(e_busy));
         check("done", int'(bus.done_o), int'(e_done));
         check("wr_valid", int'(bus.wr_valid_o), int'(e_wrv));
         if (e_wrv && bus.wr_valid_o) begin
            check("wr_addr_a", int'(bus.wr_addr_a_o), e_wa);
            check("wr_addr_b", int'(bus.wr_addr_b_o), e_wb);
         end
      end
      if (rst_n && sb_en) begin
         if (bus.rd_valid_o) begin
            int s;
            r_cnt++;
            s = (r_cnt - 1) / 128;
            if (s > 0) check("read_after_prev_stage_writes", int'(w_cnt >= 128 * s), 1);
         end
         if (bus.wr_valid_o) begin
            int s;
            w_cnt++;
            s = (w_cnt - 1) / 128;
            if (s < 8) begin
               hits[s][bus.wr_addr_a_o]++;
               hits[s][bus.wr_addr_b_o]++;
            end
         end
         if (bus.done_o) d_cnt++;
      end
   end

   task automatic run_transform(input bit mode, input int stall_pct, input bit stall_win,
                                input bit noise, input int abort_stage, output int done_cyc);
      bit st, fin, n_rdv, n_red, n_busy, n_done;
      int win_left, post, n_a, n_b, n_tw, bad;
      build_list(int'(mode));
      for (int s = 0; s < 8; s++)
         for (int a = 0; a < 256; a++) hits[s][a] = 0;
      r_cnt = 0; w_cnt = 0; d_cnt = 0;
      done_cyc = -1;
      win_left = stall_win ? 5 : 0;

      @(posedge clk); #1;
      bus.start_i = 1'b1;
      bus.mode_i  = mode;
      bus.stall_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      bus.start_i = 1'b0;

      m_phase = 1; m_stage = 0; m_k = 0; m_dl = 0; m_idx = 0;
      hv[0] = 1'b0;
      e_rdv = 0; e_red = 0; e_sb = mode; e_busy = 1; e_done = 0; e_stage = 0; e_wrv = 0;
      e_en = 1; sb_en = 1;
      fin = 0; post = 0;

      for (int c = 0; c < 4000 && !fin; c++) begin
         st = ($urandom_range(0, 99) < stall_pct);
         if (stall_win && m_phase == 1 && m_stage == 3 && m_k == 40 && win_left > 0) begin
            st = 1'b1;
            win_left--;
         end
         bus.stall_i = st;
         bus.mode_i  = 1'($urandom_range(0, 1));
         bus.start_i = (noise && (m_phase == 1 || m_phase == 2)) ? 1'($urandom_range(0, 1)) : 1'b0;

         if (abort_stage >= 0 && m_phase == 1 && m_stage == abort_stage && m_k == 10) begin
            e_en = 0; sb_en = 0;
            bus.start_i = 1'b0;
            #2 rst_n = 1'b0;
            #1 check_zero("abort");
            repeat (3) @(posedge clk);
            #1 check("abort_no_done", int'(bus.done_o), 0);
            check("abort_done_count", d_cnt, 0);
            rst_n = 1'b1;
            e_rdv = 0; e_red = 0; e_sb = 0; e_busy = 0; e_done = 0; e_stage = 0; e_wrv = 0;
            e_en = 1;
            return;
         end

         n_rdv = 0; n_red = 0; n_done = 0;
         n_a = e_a; n_b = e_b; n_tw = e_tw;
         n_busy = (m_phase != 0);
         case (m_phase)
            1: if (!st) begin
                  n_rdv = 1;
                  n_a = exp_a[m_idx]; n_b = exp_b[m_idx]; n_tw = exp_tw[m_idx];
                  n_red = exp_red[m_idx][0];
                  m_idx++; m_k++;
                  if (m_k == 128) begin m_phase = 2; m_dl = PL; end
               end
            2: begin
                  m_dl--;
                  if (m_dl == 0) begin
                     if (m_stage == 7) m_phase = 3;
                     else begin m_stage++; m_k = 0; m_phase = 1; end
                  end
               end
            3: begin n_done = 1; m_phase = 0; end
            default: ;
         endcase

         @(posedge clk); #1;
         hv[c+1] = n_rdv; ha[c+1] = n_a; hb[c+1] = n_b;
         e_rdv = n_rdv; e_a = n_a; e_b = n_b; e_tw = n_tw; e_red = n_red;
         e_busy = n_busy; e_done = n_done; e_stage = m_stage;
         if (c + 1 >= PL) begin
            e_wrv = hv[c+1-PL]; e_wa = ha[c+1-PL]; e_wb = hb[c+1-PL];
         end else begin
            e_wrv = 0;
         end
         if (n_done) done_cyc = c + 1;
         if (m_phase == 0) begin
            post++;
            if (post == 2) fin = 1;
         end
      end

      check("transform_finished", int'(fin), 1);
      check("done_count", d_cnt, 1);
      check("rd_count", r_cnt, 1024);
      check("wr_count", w_cnt, 1024);
      bad = 0;
      for (int s = 0; s < 8; s++)
         for (int a = 0; a < 256; a++)
            if (hits[s][a] != 1) bad++;
      check("each_index_written_once_per_stage", bad, 0);
   endtask

   initial begin
      int dc, red_sum;
      bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.stall_i = 1'b0;
      rst_n = 1'b0;
      #3 check_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      build_list(0);
      check("model_fwd_s0_a", exp_a[0], 0);
      check("model_fwd_s0_b", exp_b[0], 128);
      check("model_fwd_s0_tw", exp_tw[0], 1);
      check("model_fwd_s1_a", exp_a[128], 0);
      check("model_fwd_s1_b", exp_b[128], 64);
      check("model_fwd_s1_tw", exp_tw[128], 2);
      check("model_fwd_last_a", exp_a[1023], 254);
      check("model_fwd_last_b", exp_b[1023], 255);
      check("model_fwd_last_tw", exp_tw[1023], 255);
      build_list(1);
      check("model_inv_s0_a", exp_a[0], 0);
      check("model_inv_s0_b", exp_b[0], 1);
      check("model_inv_s0_tw", exp_tw[0], 255);
      check("model_inv_s7_a", exp_a[896], 0);
      check("model_inv_s7_b", exp_b[896], 128);
      check("model_inv_s7_tw", exp_tw[896], 1);
      check("model_inv_s7_red", exp_red[896], 1);
      red_sum = 0;
      for (int k = 0; k < 896; k++) red_sum += exp_red[k];
      check("model_inv_early_red", red_sum, 0);

      run_transform(1'b0, 0, 1'b0, 1'b0, -1, dc);
      check("done_cycle_fwd", dc, 1041);
      run_transform(1'b1, 0, 1'b0, 1'b0, -1, dc);
      check("done_cycle_inv", dc, 1041);
      run_transform(1'b0, 0, 1'b1, 1'b0, -1, dc);
      check("done_cycle_stall5", dc, 1046);
      run_transform(1'b1, 0, 1'b0, 1'b1, -1, dc);
      check("done_cycle_start_noise", dc, 1041);
      run_transform(1'b0, 10, 1'b0, 1'b1, 4, dc);
      run_transform(1'b0, 0, 1'b0, 1'b0, -1, dc);
      check("done_cycle_after_abort", dc, 1041);
      for (int r = 0; r < 4; r++) begin
         run_transform(1'($urandom_range(0, 1)), int'($urandom_range(0, 30)), 1'b0, 1'b1, -1, dc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
